// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: arbitrates icache fill and dcache requests onto one RAM port
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   iREN, iaddr          icache read request and word address
//   iwait, iload         icache stall (low only on completion) and read data
//   dREN, dWEN           dcache read / write request (write wins when both high)
//   daddr, dstore        dcache word address and write data
//   dwait, dload         dcache stall (low only on completion) and read data
//   ramREN, ramWEN       RAM read / write strobes
//   ramaddr, ramstore    RAM address and write data (0 when idle)
//   ramload, ramstate    RAM read data and status (FREE, BUSY, ACCESS, ERROR)
//   mem_err              sticky flag, set when RAM reports ERROR during a grant
module cache_mem_arbiter #(
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DSTREAK_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              mem_err
);
    localparam int SW = $clog2(DSTREAK_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(DSTREAK_MAX);
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR = 2'd3;

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    state_t state;
    logic [SW-1:0] streak;
    logic dreq, d_act, i_act;

    // a grant only drives RAM while its requester still holds the request
    assign dreq = dREN | dWEN;
    assign d_act = (state == DGNT) && dreq;
    assign i_act = (state == IGNT) && iREN;

    always_comb begin
        ramWEN   = d_act && dWEN;
        ramREN   = (d_act && !dWEN) || i_act;
        ramaddr  = d_act ? daddr : i_act ? iaddr : '0;
        ramstore = (d_act && dWEN) ? dstore : '0;
        dwait    = !(d_act && ramstate == ACCESS);
        iwait    = !(i_act && ramstate == ACCESS);
        iload    = ramload;
        dload    = ramload;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            streak  <= '0;
            mem_err <= 1'b0;
        end else begin
            if ((d_act || i_act) && ramstate == ERROR)
                mem_err <= 1'b1;
            case (state)
                IDLE:
                    // dcache wins unless icache has waited through a full streak
                    if (dreq && !(iREN && streak == SMAX))
                        state <= DGNT;
                    else if (iREN)
                        state <= IGNT;
                DGNT:
                    if (!dreq)
                        state <= IDLE;
                    else if (ramstate == ACCESS) begin
                        state  <= IDLE;
                        streak <= !iREN ? '0 : (streak == SMAX) ? SMAX : streak + SW'(1);
                    end
                IGNT:
                    if (!iREN)
                        state <= IDLE;
                    else if (ramstate == ACCESS) begin
                        state  <= IDLE;
                        streak <= '0;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
    logic        CLK, nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, mem_err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    int checks = 0;
    int fails = 0;

    cache_mem_arbiter #(.WORD_W(32), .ADDR_W(32), .DSTREAK_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = 2'd0;
    endtask

    task automatic test_reset();
        nRST = 0;
        idle_inputs();
        #3;
        checks++;
        if ({iwait, dwait, ramREN, ramWEN, mem_err} !== 5'b11000 || ramaddr !== 0 || ramstore !== 0) begin
            fails++;
            $display("FAIL reset: iwait,dwait,ramREN,ramWEN,mem_err=%b ramaddr=%h ramstore=%h, expected 11000 0 0",
                     {iwait, dwait, ramREN, ramWEN, mem_err}, ramaddr, ramstore);
        end
        @(negedge CLK);
        nRST = 1;
    endtask

    task automatic test_icache_read();
        @(negedge CLK);
        iREN = 1; iaddr = 32'h40;
        #1;
        checks++;
        if ({ramREN, iwait} !== 2'b01) begin
            fails++; $display("FAIL iread_idle: ramREN,iwait=%b expected 01", {ramREN, iwait});
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            ramstate = 2'd1;
            #1;
            checks++;
            if ({ramREN, ramWEN, iwait, dwait} !== 4'b1011 || ramaddr !== 32'h40) begin
                fails++;
                $display("FAIL iread_busy%0d: ramREN,ramWEN,iwait,dwait=%b ramaddr=%h expected 1011 00000040",
                         c, {ramREN, ramWEN, iwait, dwait}, ramaddr);
            end
        end
        @(negedge CLK);
        ramstate = 2'd2; ramload = 32'hDEADBEEF;
        #1;
        checks++;
        if ({iwait, dwait} !== 2'b01 || iload !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL iread_access: iwait,dwait=%b iload=%h expected 01 deadbeef", {iwait, dwait}, iload);
        end
        @(negedge CLK);
        idle_inputs();
        #1;
        checks++;
        if ({iwait, ramREN} !== 2'b10 || ramaddr !== 0) begin
            fails++;
            $display("FAIL iread_after: iwait,ramREN=%b ramaddr=%h expected 10 0", {iwait, ramREN}, ramaddr);
        end
    endtask

    task automatic test_priority();
        @(negedge CLK);
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
        #1;
        checks++;
        if ({ramREN, ramWEN} !== 2'b00) begin
            fails++; $display("FAIL prio_idle: ramREN,ramWEN=%b expected 00", {ramREN, ramWEN});
        end
        @(negedge CLK);
        #1;
        checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0111 || ramaddr !== 32'h80 || ramstore !== 32'h1234) begin
            fails++;
            $display("FAIL prio_dgnt: ramREN,ramWEN,iwait,dwait=%b ramaddr=%h ramstore=%h expected 0111 80 1234",
                     {ramREN, ramWEN, iwait, dwait}, ramaddr, ramstore);
        end
        ramstate = 2'd2;
        #1;
        checks++;
        if ({iwait, dwait} !== 2'b10) begin
            fails++; $display("FAIL prio_dwrite_done: iwait,dwait=%b expected 10", {iwait, dwait});
        end
        @(negedge CLK);
        dWEN = 0; dstore = 0; daddr = 0; ramstate = 2'd0;
        #1;
        checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            fails++; $display("FAIL prio_bubble: ramREN,ramWEN,iwait,dwait=%b expected 0011", {ramREN, ramWEN, iwait, dwait});
        end
        @(negedge CLK);
        ramstate = 2'd2; ramload = 32'h55AA;
        #1;
        checks++;
        if ({ramREN, ramWEN, iwait} !== 3'b100 || ramaddr !== 32'h44 || iload !== 32'h55AA) begin
            fails++;
            $display("FAIL prio_ignt: ramREN,ramWEN,iwait=%b ramaddr=%h iload=%h expected 100 44 55aa",
                     {ramREN, ramWEN, iwait}, ramaddr, iload);
        end
        @(negedge CLK);
        idle_inputs();
    endtask

    task automatic test_starvation();
        int n;
        string seq;
        string exp;
        n = 0; seq = ""; exp = "ddddiddddi";
        @(negedge CLK);
        iREN = 1; iaddr = 32'hA0; dREN = 1; daddr = 32'hB0; ramstate = 2'd2;
        for (int c = 0; c < 40 && n < 10; c++) begin
            #1;
            if (!iwait && !dwait) begin
                checks++; fails++;
                $display("FAIL starve_both: both waits low in cycle %0d", c);
            end
            if (!dwait || !iwait) begin
                seq = {seq, (!dwait ? "d" : "i")};
                checks++;
                if (seq[n] !== exp[n]) begin
                    fails++;
                    $display("FAIL starve_order%0d: got %s expected %s", n, seq.substr(n, n), exp.substr(n, n));
                end
                n++;
            end
            @(negedge CLK);
        end
        checks++;
        if (n !== 10) begin
            fails++; $display("FAIL starve_count: %0d completions expected 10", n);
        end
        idle_inputs();
    endtask

    task automatic test_abort();
        @(negedge CLK);
        dREN = 1; daddr = 32'h90; ramstate = 2'd1;
        @(negedge CLK);
        #1;
        checks++;
        if ({ramREN, dwait} !== 2'b11 || ramaddr !== 32'h90) begin
            fails++; $display("FAIL abort_grant: ramREN,dwait=%b ramaddr=%h expected 11 90", {ramREN, dwait}, ramaddr);
        end
        @(negedge CLK);
        dREN = 0; ramstate = 2'd2;
        #1;
        checks++;
        if ({ramREN, ramWEN, dwait} !== 3'b001 || ramaddr !== 0) begin
            fails++;
            $display("FAIL abort_drop: ramREN,ramWEN,dwait=%b ramaddr=%h expected 001 0", {ramREN, ramWEN, dwait}, ramaddr);
        end
        @(negedge CLK);
        dREN = 1;
        #1;
        checks++;
        if ({ramREN, dwait} !== 2'b01) begin
            fails++; $display("FAIL abort_idle: ramREN,dwait=%b expected 01", {ramREN, dwait});
        end
        @(negedge CLK);
        #1;
        checks++;
        if ({ramREN, dwait} !== 2'b10) begin
            fails++; $display("FAIL abort_retry: ramREN,dwait=%b expected 10", {ramREN, dwait});
        end
        @(negedge CLK);
        idle_inputs();
    endtask

    task automatic test_error_and_reset();
        @(negedge CLK);
        iREN = 1; iaddr = 32'h100;
        @(negedge CLK);
        ramstate = 2'd3;
        #1;
        checks++;
        if ({ramREN, iwait, mem_err} !== 3'b110) begin
            fails++; $display("FAIL err_first: ramREN,iwait,mem_err=%b expected 110", {ramREN, iwait, mem_err});
        end
        @(negedge CLK);
        #1;
        checks++;
        if ({ramREN, iwait, mem_err} !== 3'b111) begin
            fails++; $display("FAIL err_second: ramREN,iwait,mem_err=%b expected 111", {ramREN, iwait, mem_err});
        end
        @(negedge CLK);
        ramstate = 2'd2; ramload = 32'hCAFEF00D;
        #1;
        checks++;
        if ({iwait, mem_err} !== 2'b01 || iload !== 32'hCAFEF00D) begin
            fails++; $display("FAIL err_access: iwait,mem_err=%b iload=%h expected 01 cafef00d", {iwait, mem_err}, iload);
        end
        @(negedge CLK);
        idle_inputs();
        #1;
        checks++;
        if (mem_err !== 1'b1) begin
            fails++; $display("FAIL err_sticky: mem_err=%b expected 1", mem_err);
        end
        @(negedge CLK);
        iREN = 1; iaddr = 32'h200; ramstate = 2'd1;
        @(negedge CLK);
        #1;
        checks++;
        if ({ramREN, iwait} !== 2'b11 || ramaddr !== 32'h200) begin
            fails++; $display("FAIL rst_pre: ramREN,iwait=%b ramaddr=%h expected 11 200", {ramREN, iwait}, ramaddr);
        end
        #1;
        nRST = 0;
        ramstate = 2'd2;
        #1;
        checks++;
        if ({iwait, dwait, ramREN, ramWEN, mem_err} !== 5'b11000 || ramaddr !== 0 || ramstore !== 0) begin
            fails++;
            $display("FAIL rst_async: iwait,dwait,ramREN,ramWEN,mem_err=%b ramaddr=%h ramstore=%h expected 11000 0 0",
                     {iwait, dwait, ramREN, ramWEN, mem_err}, ramaddr, ramstore);
        end
        @(negedge CLK);
        idle_inputs();
        nRST = 1;
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_priority();
        test_starvation();
        test_abort();
        test_error_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
